// File: rtl/i2c_mem_slave.sv
// I2C memory responder: one-byte read/write frames addressed by a 7-bit location into a 128 x 8 RAM.
// scl is observed only; sda is open-drain and is only ever driven low.
module i2c_mem_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MEM_DEPTH   = 128
) (
  input  logic       rst,
  input  logic       clk,
  inout  wire        scl,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ackErr,
  output logic [6:0] lastLoc,
  output logic [7:0] lastData
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, RACK, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]             bit_cnt;
  logic [6:0]             shifter;
  logic [6:0]             loc;
  logic                   rw;
  logic                   ack_on;
  logic                   sda_low;
  logic                   mem_we;
  logic [7:0]             wr_byte;
  logic [7:0]             mem [MEM_DEPTH];

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Synchronizers idle high so that reset never looks like a bus event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_prev;
  assign scl_fall = ~scl_s & scl_prev;
  assign start_c  = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_c   = scl_s & scl_prev & ~sda_prev & sda_s;

  assign wr_byte = {shifter, sda_s};
  assign mem_we  = (state == WDATA) && scl_rise && (bit_cnt == 3'd7) && !start_c && !stop_c;

  // NOTE: the RAM has no reset so it maps onto a memory macro; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (mem_we) mem[loc] <= wr_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sda_low  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ackErr   <= 1'b0;
      lastLoc  <= '0;
      lastData <= '0;
      bit_cnt  <= '0;
      shifter  <= '0;
      loc      <= '0;
      rw       <= 1'b0;
      ack_on   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_c) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_low <= 1'b0;
        ackErr  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_c) begin
        state   <= IDLE;
        sda_low <= 1'b0;
        busy    <= 1'b0;
      end else begin
        unique case (state)
          ADDR: if (scl_rise) begin
            shifter <= wr_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              loc     <= shifter;
              lastLoc <= shifter;
              rw      <= sda_s;
              ack_on  <= 1'b0;
              state   <= ACK_A;
            end
          end
          // First sclFall starts the ACK window, the second ends it.
          ACK_A: if (scl_fall) begin
            if (!ack_on) begin
              ack_on  <= 1'b1;
              sda_low <= 1'b1;
            end else if (rw) begin
              shifter <= mem[loc][6:0];
              sda_low <= ~mem[loc][7];
              bit_cnt <= '0;
              state   <= RDATA;
            end else begin
              sda_low <= 1'b0;
              bit_cnt <= '0;
              state   <= WDATA;
            end
          end
          WDATA: if (scl_rise) begin
            shifter <= wr_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              lastData <= wr_byte;
              done     <= 1'b1;
              ack_on   <= 1'b0;
              state    <= ACK_W;
            end
          end
          ACK_W: if (scl_fall) begin
            if (!ack_on) begin
              ack_on  <= 1'b1;
              sda_low <= 1'b1;
            end else begin
              sda_low <= 1'b0;
              state   <= WAIT_STOP;
            end
          end
          RDATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_low <= 1'b0;
              state   <= RACK;
            end else begin
              sda_low <= ~shifter[6];
              shifter <= {shifter[5:0], 1'b0};
            end
          end
          RACK: if (scl_rise) begin
            if (!sda_s) ackErr <= 1'b1;
            done     <= 1'b1;
            lastData <= mem[loc];
            state    <= WAIT_STOP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Bench for i2c_mem_slave: a bit-banged I2C master drives frames, expected done-time results
// are queued at issue and popped by an independent monitor on every done pulse.
module tb_i2c_mem_slave;

  localparam int QTR = 8;  // clks per quarter scl period

  typedef struct packed {
    logic [6:0] loc;
    logic [7:0] data;
    logic       ack_err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_drv;
  logic       m_low;
  wire        scl;
  wire        sda;
  logic       busy, done, ackErr;
  logic [6:0] lastLoc;
  logic [7:0] lastData;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  assign scl = scl_drv;
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_mem_slave #(.SYNC_STAGES(2), .MEM_DEPTH(128)) dut (
    .rst(rst), .clk(clk), .scl(scl), .sda(sda),
    .busy(busy), .done(done), .ackErr(ackErr),
    .lastLoc(lastLoc), .lastData(lastData)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_lastLoc", 32'(lastLoc), 32'(e.loc));
        check("done_lastData", 32'(lastData), 32'(e.data));
        check("done_ackErr", 32'(ackErr), 32'(e.ack_err));
      end
    end
  end

  task automatic q();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; q();
    scl_drv = 1'b1; q();
    m_low = 1'b1; q();
    scl_drv = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; q();
    scl_drv = 1'b1; q();
    m_low = 1'b0; q();
  endtask

  task automatic send_bit(input logic b, output logic s);
    m_low = ~b; q();
    scl_drv = 1'b1; q();
    s = sda; q();
    scl_drv = 1'b0; q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(~master_ack, s);
  endtask

  task automatic push_exp(input logic [6:0] loc, input logic [7:0] data, input logic ae);
    exp_t e;
    e.loc = loc; e.data = data; e.ack_err = ae;
    exp_q.push_back(e);
  endtask

  task automatic wr_frame(input logic [6:0] loc, input logic [7:0] data);
    logic a;
    push_exp(loc, data, 1'b0);
    i2c_start();
    check("wr_busy", 32'(busy), 32'd1);
    write_byte({loc, 1'b0}, a);
    check("wr_addr_ack", 32'(a), 32'd0);
    write_byte(data, a);
    check("wr_data_ack", 32'(a), 32'd0);
    i2c_stop();
    check("wr_busy_after_stop", 32'(busy), 32'd0);
  endtask

  task automatic rd_frame(input logic [6:0] loc, input logic [7:0] exp_d, input logic master_ack);
    logic       a;
    logic [7:0] d;
    push_exp(loc, exp_d, master_ack);
    i2c_start();
    write_byte({loc, 1'b1}, a);
    check("rd_addr_ack", 32'(a), 32'd0);
    read_byte(master_ack, d);
    check("rd_data", 32'(d), 32'(exp_d));
    i2c_stop();
    check("rd_sda_released", 32'(sda), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, s;
    rst = 1'b0; scl_drv = 1'b1; m_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ackErr", 32'(ackErr), 32'd0);
    check("rst_lastLoc", 32'(lastLoc), 32'd0);
    check("rst_lastData", 32'(lastData), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    rst = 1'b1;
    q();

    // Write 0xC3 to 0x15 (address byte 0x2A), then read it back with NACK.
    wr_frame(7'h15, 8'hC3);
    check("lastLoc_after_wr", 32'(lastLoc), 32'h15);
    rd_frame(7'h15, 8'hC3, 1'b0);
    check("ackErr_after_nack", 32'(ackErr), 32'd0);
    check("lastData_after_rd", 32'(lastData), 32'hC3);

    // Master ACKs the read byte: ackErr sticks past STOP and clears on next START.
    rd_frame(7'h15, 8'hC3, 1'b1);
    check("ackErr_sticky", 32'(ackErr), 32'd1);
    wr_frame(7'h00, 8'h5A);
    check("ackErr_cleared", 32'(ackErr), 32'd0);

    // Write aborted after four data bits leaves memory untouched.
    i2c_start();
    write_byte(8'h00, a);
    check("abort_addr_ack", 32'(a), 32'd0);
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s); send_bit(1'b0, s);
    i2c_stop();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sda", 32'(sda), 32'd1);
    rd_frame(7'h00, 8'h5A, 1'b0);

    // Repeated START part-way through an address byte.
    i2c_start();
    send_bit(1'b1, s); send_bit(1'b1, s); send_bit(1'b0, s);
    wr_frame(7'h08, 8'h77);
    rd_frame(7'h08, 8'h77, 1'b0);

    // Reset while the slave holds the address ACK low.
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] ab;
      ab = 8'h2A;
      send_bit(ab[i], s);
    end
    m_low = 1'b0; q();
    check("ackA_sda_low", 32'(sda), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_lastLoc", 32'(lastLoc), 32'd0);
    check("midrst_lastData", 32'(lastData), 32'd0);
    check("midrst_ackErr", 32'(ackErr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q();
    i2c_stop();
    rd_frame(7'h15, 8'hC3, 1'b0);
    check("post_rst_lastLoc", 32'(lastLoc), 32'h15);

    q();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
